// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sizing helper for the restoring divider
//
// Purpose: one place for the FSM state encoding and the iteration-counter
// width, so the controller and any future sibling arithmetic units agree.
// Ports: none (package).
package div_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_SUB   = 2'b10;
   localparam logic [1:0] ST_DONE  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      SUB   = ST_SUB,
      DONE  = ST_DONE
   } state_t;

   // The counter is loaded with n and counts down to 0, so it must hold n.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/divider_datapath.sv
// rtl/divider_datapath.sv - A/Q/M registers, subtractor and shifter of the restoring divider
//
// Purpose: holds the partial remainder A (N+1 bits, MSB is the sign),
// the dividend/quotient shift register Q and the divisor M. The controller
// steers it with one-hot load/shift/sub strobes.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (clears A, Q, M)
//   load          capture dividend/divisor, clear A
//   shift         {A,Q} <<= 1, Q[0] <= 0
//   sub           trial subtract of M from A, restore on negative
//   dividend      operand captured on load
//   divisor       operand captured on load
//   q_sub         Q as it will be after this cycle's sub step
//   rem_sub       low N bits of A as it will be after this cycle's sub step
module divider_datapath #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         shift,
   input  logic         sub,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] q_sub,
   output logic [N-1:0] rem_sub
);

   logic [N:0]   a_q, a_d;
   logic [N-1:0] q_q, q_d;
   logic [N-1:0] m_q, m_d;

   logic [N:0]   diff;
   logic         diff_neg;
   logic [N:0]   a_sub;

   // Full N+1-bit subtract: after a shift A can reach 2*M-1, which needs
   // the extra bit, and the borrow lands in diff[N] for the sign test.
   always_comb begin
      diff     = a_q - {1'b0, m_q};
      diff_neg = diff[N];
      a_sub    = diff_neg ? a_q : diff;
      q_sub    = {q_q[N-1:1], ~diff_neg};
      rem_sub  = a_sub[N-1:0];
   end

   always_comb begin
      a_d = a_q;
      q_d = q_q;
      m_d = m_q;
      if (load) begin
         a_d = '0;
         q_d = dividend;
         m_d = divisor;
      end else if (shift) begin
         {a_d, q_d} = {a_q[N-1:0], q_q, 1'b0};
      end else if (sub) begin
         a_d = a_sub;
         q_d = q_sub;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q <= '0;
         q_q <= '0;
         m_q <= '0;
      end else begin
         a_q <= a_d;
         q_q <= q_d;
         m_q <= m_d;
      end
   end

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider, controller and result registers
//
// Purpose: N-bit unsigned divide, one quotient bit per SHIFT+SUB pair.
// A zero divisor short-cuts straight to DONE with quotient=all ones,
// remainder=dividend and div_by_zero set.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         request, sampled only in IDLE
//   dividend      numerator, captured on the accepting edge
//   divisor       denominator, captured on the accepting edge
//   quotient      registered result, held until the next completion
//   remainder     registered result, held until the next completion
//   done          one-cycle pulse while in DONE
//   busy          high whenever not in IDLE
//   div_by_zero   registered zero-divisor flag, updated with done
module restoring_divider #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         done,
   output logic         busy,
   output logic         div_by_zero
);

   import div_pkg::*;

   localparam int CW = cnt_width(N);

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [N-1:0]  quotient_q, quotient_d;
   logic [N-1:0]  remainder_q, remainder_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic          dbz_q, dbz_d;

   logic          dp_load, dp_shift, dp_sub;
   logic [N-1:0]  q_sub;
   logic [N-1:0]  rem_sub;

   divider_datapath #(.N(N)) u_datapath (
      .clk      (clk),
      .rst      (rst),
      .load     (dp_load),
      .shift    (dp_shift),
      .sub      (dp_sub),
      .dividend (dividend),
      .divisor  (divisor),
      .q_sub    (q_sub),
      .rem_sub  (rem_sub)
   );

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      dp_load     = 1'b0;
      dp_shift    = 1'b0;
      dp_sub      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor != '0) begin
                  dp_load = 1'b1;
                  count_d = CW'(N);
                  state_d = SHIFT;
               end else begin
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
                  state_d     = DONE;
               end
            end
         end
         SHIFT: begin
            dp_shift = 1'b1;
            count_d  = count_q - CW'(1);
            state_d  = SUB;
         end
         SUB: begin
            dp_sub = 1'b1;
            // count was already decremented in SHIFT, so 0 here means the
            // bit just resolved is the last one.
            if (count_q != '0) begin
               state_d = SHIFT;
            end else begin
               quotient_d  = q_sub;
               remainder_d = rem_sub;
               dbz_d       = 1'b0;
               state_d     = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         dbz_q       <= dbz_d;
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign done        = done_q;
   assign busy        = busy_q;
   assign div_by_zero = dbz_q;

endmodule
